sb_line_streamer: RTL and testbench
===================================

# sb_line_streamer

Read-side streamer placed directly downstream of the 64×512-bit shared buffer. It accepts a (start address, line count) command, issues single-cycle reads to the buffer's active-low port, and absorbs the buffer's fixed 1-cycle read latency. Lines are returned to the consumer (compute array / DMA-out) over a valid/ready stream with full throughput and lossless backpressure. The block never writes the buffer.

## Interface
- AW, 6, buffer address width (64 lines)
- DW, 512, line width
- FD, 2, output FIFO depth in lines (≥2)

- CLK  input  1  clock, all logic on rising edge
- RST  input  1  synchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  high only in IDLE
- cmd_addr  input  AW  first line address
- cmd_len  input  AW+1  line count, 0..64
- sb_cen  output  1  buffer chip enable, active-low
- sb_wen  output  1  buffer write enable, tied 1
- sb_retn  output  1  buffer retention, tied 1
- sb_a  output  AW  buffer address
- sb_q  input  DW  buffer read data, valid the cycle after sb_cen low
- out_valid  output  1  line available
- out_ready  input  1  consumer accepts
- out_data  output  DW  line data (FIFO head)
- out_last  output  1  final line of the command, qualified by out_valid
- busy  output  1  high when state ≠ IDLE
- done  output  1  one-cycle pulse on command completion

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid, latch addr→rd_addr, len→remaining, len→beats_left.
  - len≠0 → RUN. len=0 → stay IDLE, pulse done next cycle, no read issued.
- RUN: issue a read (sb_cen=0, sb_a=rd_addr) when remaining>0 and fifo_count + inflight − pop < FD, where pop = out_valid & out_ready this cycle. On issue: rd_addr+1 modulo 64 (63→0 wrap), remaining−1. When the last read issues → DRAIN.
- inflight: 1-bit flag, set for the cycle after an issue; that cycle sb_q is pushed into the FIFO. The capture slot is always reserved by the credit check, so overflow is impossible.
- DRAIN: no reads; sb_cen=1. When the beat with out_last is popped → IDLE, done pulses next cycle.
- out_last = out_valid & (beats_left==1). beats_left decrements on each pop.
- sb_wen=1 and sb_retn=1 at all times, including reset. sb_cen=1 whenever no read issues. sb_a holds its last value when idle.
- Ordering: lines emerge in address order. No reordering, no drops, no duplicates.
- New commands are not accepted until done has been generated: cmd_ready=0 in RUN and DRAIN.

## Timing
- Reset values: cmd_ready=0 during RST, 1 the cycle after; sb_cen=1; sb_a=0; out_valid=0; out_last=0; busy=0; done=0; FIFO empty; inflight=0; state IDLE.
- RST in any state: abort immediately. Flush FIFO and in-flight capture; any sb_q arriving the next cycle is ignored. No done pulse.
- Command accepted at edge E0:
  - first read in cycle after E0 (E0+1);
  - sb_q valid in E0+2, pushed at the end of E0+2;
  - out_valid in E0+3.
  - Issue-to-out_valid = 2 cycles.
- Throughput: 1 line/cycle with out_ready held high. A len=N command finishes the last pop at cycle E0+N+2; done is high in E0+N+3.
- Backpressure: when out_ready is low, issue stalls once the FIFO plus the in-flight capture reach FD. Resumes in the same cycle a pop occurs.
- Simultaneous push and pop: count unchanged. Pop of the only entry with no push: out_valid drops the next cycle.

## Test plan
- Preload lines 0..63 with pattern {8{addr,56'hA5}}. Command addr=4, len=4, out_ready=1 → lines 4,5,6,7 on out_valid in consecutive cycles E0+3..E0+6; out_last only with line 7; done in E0+7.
- Wrap-around: addr=62, len=4 → sb_a sequence 62,63,0,1; output data matches lines 62,63,0,1.
- Backpressure: len=8, out_ready toggled 1,0,0,1,0,1… → all 8 lines in order, none lost or duplicated. fifo_count+inflight never exceeds 2. sb_cen stays high while the FIFO is full and out_ready=0.
- len=0 → no sb_cen low cycle, out_valid never asserts, done pulses once the cycle after acceptance. len=64 from addr=0 → 64 lines, out_last on line 63.
- Reset mid-op: len=16, assert RST for 1 cycle after 5 pops → next cycle out_valid=0, sb_cen=1, busy=0, no done. A new command addr=0, len=2 then runs correctly.
- Back-to-back: cmd_valid held high with two commands → cmd_ready=0 through RUN/DRAIN. The second command is accepted in the cycle done is high, and its first read issues the cycle after.

Source files
------------

// File: rtl/sb_line_streamer_if.sv
// Bundle of command, buffer-port and output-stream signals for sb_line_streamer.
// The master view belongs to the streamer; the slave view belongs to whatever
// surrounds it (command source, 1-cycle-latency buffer and line consumer).
interface sb_line_streamer_if #(
    parameter int AW = 6,
    parameter int DW = 512
);
    // command channel
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    // buffer read port (active-low controls)
    logic          sb_cen;
    logic          sb_wen;
    logic          sb_retn;
    logic [AW-1:0] sb_a;
    logic [DW-1:0] sb_q;
    // output line stream
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    // status
    logic          busy;
    logic          done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, sb_q, out_ready,
        output cmd_ready, sb_cen, sb_wen, sb_retn, sb_a,
               out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, sb_q, out_ready,
        input  cmd_ready, sb_cen, sb_wen, sb_retn, sb_a,
               out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/sb_line_streamer.sv
// Read-side streamer for the shared line buffer: turns an (addr, len) command
// into single-cycle reads, absorbs the 1-cycle read latency through a small
// output FIFO and presents lines on a valid/ready stream.
module sb_line_streamer #(
    parameter int AW = 6,
    parameter int DW = 512,
    parameter int FD = 2
) (
    input  logic                CLK,
    input  logic                RST,
    sb_line_streamer_if.master  bus
);
    localparam int PW   = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW   = $clog2(FD + 1);
    localparam int CMPW = CW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_rd_addr;
    logic [AW:0]     r_remaining;
    logic [AW:0]     r_beats_left;
    logic            r_done;
    logic            r_inflight;

    logic [DW-1:0]   r_fifo [FD];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_out_valid;
    logic            w_pop;
    logic            w_last;
    logic            w_issue;
    logic [CMPW-1:0] w_used;
    logic [CMPW-1:0] w_limit;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
    endfunction

    // Read issue: the capture slot of an in-flight read is already counted as
    // occupied, and a pop in this same cycle frees a slot immediately.
    always_comb begin
        w_out_valid = (r_count != '0);
        w_pop       = w_out_valid & bus.out_ready;
        w_last      = w_out_valid & (r_beats_left == {{AW{1'b0}}, 1'b1});
        w_used      = CMPW'(r_count) + CMPW'(r_inflight);
        w_limit     = CMPW'(FD) + CMPW'(w_pop);
        w_issue     = !RST && (r_state == RUN) && (r_remaining != '0) && (w_used < w_limit);
    end

    assign bus.cmd_ready = (r_state == IDLE) && !RST;
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = r_done;
    assign bus.sb_cen    = ~w_issue;
    assign bus.sb_wen    = 1'b1;
    assign bus.sb_retn   = 1'b1;
    assign bus.sb_a      = r_rd_addr;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_fifo[r_rd_ptr];
    assign bus.out_last  = w_last;

    // Command FSM: latch command, walk the address range, wait for final pop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_rd_addr    <= '0;
            r_remaining  <= '0;
            r_beats_left <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_pop) begin
                r_beats_left <= r_beats_left - 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_rd_addr    <= bus.cmd_addr;
                        r_remaining  <= bus.cmd_len;
                        r_beats_left <= bus.cmd_len;
                        if (bus.cmd_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_issue) begin
                        r_rd_addr   <= r_rd_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == {{AW{1'b0}}, 1'b1}) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && w_last) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // FIFO control: the cycle after an issue, the buffer output is captured.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: no reset needed, occupancy is tracked by r_count.
    always_ff @(posedge CLK) begin
        if (r_inflight) begin
            r_fifo[r_wr_ptr] <= bus.sb_q;
        end
    end
endmodule

// File: tb/tb_sb_line_streamer.sv
// Bench for sb_line_streamer: buffer model with 1-cycle read latency,
// table of commands, scoreboard of expected lines and read addresses,
// plus hand-written reset-abort and back-to-back sequences.
module tb_sb_line_streamer;
    localparam int AW = 6;
    localparam int DW = 512;
    localparam int FD = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    sb_line_streamer_if #(.AW(AW), .DW(DW)) bus ();

    sb_line_streamer #(.AW(AW), .DW(DW), .FD(FD)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        int unsigned addr;
        int unsigned len;
        int unsigned mode;      // 0: ready held high, 1: 1,0,0,1,0,1 pattern, 2: random
        int          exp_done_k;  // cycle after acceptance with done high, 0 = not checked
        int          exp_first_k; // cycle after acceptance with first out_valid, 0 = not checked
    } vec_t;

    logic [DW-1:0] mem [64];
    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];

    int tests = 0;
    int fails = 0;
    int pop_cnt = 0;
    int issue_cnt = 0;
    int done_cnt = 0;
    int outst = 0;
    int max_outst = 0;
    bit mon_en = 1'b0;
    logic [5:0] pat = 6'b101001;

    function automatic logic [DW-1:0] line_of(input int unsigned a);
        logic [7:0] a8;
        a8 = 8'(a);
        return {8{a8, 56'hA5}};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    // buffer model: data appears the cycle after chip enable is low
    always @(posedge CLK) begin
        if (!bus.sb_cen) bus.sb_q <= mem[bus.sb_a];
    end

    // monitor: checks read addresses, stream contents and occupancy
    always @(negedge CLK) begin
        bit iss;
        bit pp;
        if (mon_en && !RST) begin
            iss = (bus.sb_cen == 1'b0);
            pp  = bus.out_valid && bus.out_ready;
            if (bus.done) done_cnt++;
            if (iss) begin
                issue_cnt++;
                if (addr_q.size() == 0) fail_now("unexpected_read");
                else chk("sb_a", DW'(bus.sb_a), DW'(addr_q.pop_front()));
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) fail_now("unexpected_valid");
                else begin
                    chk("out_data", bus.out_data, exp_q[0].data);
                    chk("out_last", DW'(bus.out_last), DW'(exp_q[0].last));
                    if (pp) void'(exp_q.pop_front());
                end
            end else begin
                chk("out_last_idle", DW'(bus.out_last), '0);
            end
            if (pp) pop_cnt++;
            outst = outst + int'(iss) - int'(pp);
            if (outst > max_outst) max_outst = outst;
        end
    end

    task automatic enqueue(input int unsigned addr, input int unsigned len);
        for (int unsigned i = 0; i < len; i++) begin
            exp_t e;
            e.data = line_of((addr + i) % 64);
            e.last = (i == len - 1);
            exp_q.push_back(e);
            addr_q.push_back(AW'((addr + i) % 64));
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int done_k, first_k, dcnt0, pcnt0, icnt0;
        enqueue(v.addr, v.len);
        max_outst = 0;
        dcnt0 = done_cnt; pcnt0 = pop_cnt; icnt0 = issue_cnt;
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = AW'(v.addr);
        bus.cmd_len   = (AW+1)'(v.len);
        bus.out_ready = 1'b1;
        @(negedge CLK);
        chk("cmd_ready_idle", DW'(bus.cmd_ready), DW'(1));
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b0;
        done_k = 0; first_k = 0;
        for (int k = 1; k <= 600; k++) begin
            case (v.mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = pat[k % 6];
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge CLK);
            if (bus.out_valid && first_k == 0) first_k = k;
            if (bus.done && done_k == 0) done_k = k;
            if (done_k != 0 && k >= done_k + 2) break;
            @(posedge CLK); #1;
        end
        bus.out_ready = 1'b1;
        if (done_k == 0) fail_now("done_timeout");
        else if (v.exp_done_k != 0) chk("done_cycle", DW'(done_k), DW'(v.exp_done_k));
        if (v.exp_first_k != 0) chk("first_valid_cycle", DW'(first_k), DW'(v.exp_first_k));
        chk("done_pulses", DW'(done_cnt - dcnt0), DW'(1));
        chk("reads_issued", DW'(issue_cnt - icnt0), DW'(v.len));
        chk("lines_popped", DW'(pop_cnt - pcnt0), DW'(v.len));
        chk("scoreboard_empty", DW'(exp_q.size()), '0);
        chk("occupancy_le_fd", DW'(max_outst <= FD), DW'(1));
        chk("busy_after", DW'(bus.busy), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        int   dcnt0, pcnt0, bad;
        bit   got, seen;

        vt[0] = '{addr: 4,  len: 4,  mode: 0, exp_done_k: 7,  exp_first_k: 3};
        vt[1] = '{addr: 62, len: 4,  mode: 0, exp_done_k: 7,  exp_first_k: 3};
        vt[2] = '{addr: 10, len: 8,  mode: 1, exp_done_k: 0,  exp_first_k: 3};
        vt[3] = '{addr: 0,  len: 0,  mode: 0, exp_done_k: 1,  exp_first_k: 0};
        vt[4] = '{addr: 0,  len: 64, mode: 0, exp_done_k: 67, exp_first_k: 3};
        vt[5] = '{addr: 30, len: 1,  mode: 0, exp_done_k: 4,  exp_first_k: 3};
        vt[6] = '{addr: 50, len: 20, mode: 2, exp_done_k: 0,  exp_first_k: 0};

        for (int unsigned a = 0; a < 64; a++) mem[a] = line_of(a);
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b1;

        // reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_cmd_ready", DW'(bus.cmd_ready), '0);
        chk("rst_sb_cen",    DW'(bus.sb_cen), DW'(1));
        chk("rst_sb_a",      DW'(bus.sb_a), '0);
        chk("rst_out_valid", DW'(bus.out_valid), '0);
        chk("rst_out_last",  DW'(bus.out_last), '0);
        chk("rst_busy",      DW'(bus.busy), '0);
        chk("rst_done",      DW'(bus.done), '0);
        chk("rst_sb_wen",    DW'(bus.sb_wen), DW'(1));
        chk("rst_sb_retn",   DW'(bus.sb_retn), DW'(1));
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_cmd_ready", DW'(bus.cmd_ready), DW'(1));
        mon_en = 1'b1;

        for (int i = 0; i < 7; i++) run_cmd(vt[i]);

        // reset in the middle of a 16-line command
        enqueue(10, 16);
        pcnt0 = pop_cnt;
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b1; bus.cmd_addr = 6'd10; bus.cmd_len = 7'd16; bus.out_ready = 1'b1;
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (pop_cnt - pcnt0 >= 5) begin got = 1'b1; break; end
            @(posedge CLK); #1;
        end
        if (!got) fail_now("reset_wait_pops");
        mon_en = 1'b0;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("abort_out_valid", DW'(bus.out_valid), '0);
        chk("abort_sb_cen",    DW'(bus.sb_cen), DW'(1));
        chk("abort_busy",      DW'(bus.busy), '0);
        chk("abort_cmd_ready", DW'(bus.cmd_ready), DW'(1));
        seen = bus.done;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            seen = seen | bus.done | bus.out_valid;
        end
        chk("abort_quiet", DW'(seen), '0);
        exp_q.delete();
        addr_q.delete();
        outst = 0;
        mon_en = 1'b1;
        run_cmd('{addr: 0, len: 2, mode: 0, exp_done_k: 5, exp_first_k: 3});

        // back-to-back commands with cmd_valid held high
        enqueue(20, 3);
        enqueue(40, 2);
        dcnt0 = done_cnt;
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b1; bus.cmd_addr = 6'd20; bus.cmd_len = 7'd3; bus.out_ready = 1'b1;
        @(negedge CLK);
        chk("b2b_ready_first", DW'(bus.cmd_ready), DW'(1));
        @(posedge CLK); #1;
        bus.cmd_addr = 6'd40; bus.cmd_len = 7'd2;
        bad = 0; got = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge CLK);
            if (bus.done) begin
                got = 1'b1;
                chk("b2b_ready_with_done", DW'(bus.cmd_ready), DW'(1));
                chk("b2b_done_cycle", DW'(k), DW'(6));
                break;
            end else if (bus.cmd_ready) bad++;
            @(posedge CLK); #1;
        end
        if (!got) fail_now("b2b_first_done");
        chk("b2b_ready_low_busy", DW'(bad), '0);
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b0;
        @(negedge CLK);
        chk("b2b_second_issue_cen",  DW'(bus.sb_cen), '0);
        chk("b2b_second_issue_addr", DW'(bus.sb_a), DW'(40));
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (bus.done) begin got = 1'b1; break; end
            @(negedge CLK);
        end
        if (!got) fail_now("b2b_second_done");
        repeat (2) @(negedge CLK);
        chk("b2b_done_pulses", DW'(done_cnt - dcnt0), DW'(2));
        chk("b2b_scoreboard_empty", DW'(exp_q.size()), '0);
        chk("b2b_addr_q_empty", DW'(addr_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
